// File: rtl/sa_pkg.sv
// Shared definitions for the bit-serial array feeder: default geometry,
// FSM state encoding and the weight/activation mode constants.
package sa_pkg;

    localparam int DEF_SIZE     = 16;
    localparam int DEF_IN_WIDTH = 16;
    localparam int DEF_RPL      = DEF_IN_WIDTH / 8;
    localparam int DEF_LANES    = DEF_SIZE * 8 / DEF_IN_WIDTH;

    localparam logic MODE_WEIGHT = 1'b0;
    localparam logic MODE_ACT    = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/sa_lane_shifter.sv
// Parallel-load, MSB-first shift register carrying RPL bytes for one serial lane.
// Load wins over shift; shifting fills with zeros.
module sa_lane_shifter
    import sa_pkg::*;
#(
    parameter int RPL = DEF_RPL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [8*RPL-1:0] data_i,
    output logic             msb_o
);

    logic [8*RPL-1:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= data_i;
        end else if (shift_i) begin
            sr_q <= {sr_q[8*RPL-2:0], 1'b0};
        end
    end

    assign msb_o = sr_q[8*RPL-1];

endmodule

// File: rtl/sa_bitserial_feeder.sv
// Converts SIZE parallel column vectors into per-lane MSB-first bit streams for
// the systolic array, with a hold + shift buffer for gapless streaming and preload strobes.
module sa_bitserial_feeder
    import sa_pkg::*;
#(
    parameter  int SIZE     = DEF_SIZE,
    parameter  int IN_WIDTH = DEF_IN_WIDTH,
    localparam int RPL      = IN_WIDTH / 8,
    localparam int LANES    = SIZE * 8 / IN_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [8*SIZE-1:0] vec_data,
    input  logic              vec_valid,
    output logic              vec_ready,
    output logic [LANES-1:0]  data_in,
    output logic [LANES-1:0]  en_in,
    output logic              bit_valid,
    output logic              preclk,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(SIZE + 1);
    localparam int BW = $clog2(IN_WIDTH);
    localparam logic [CW-1:0] CNT_SIZE = CW'(SIZE);
    localparam logic [BW-1:0] BIT_LAST = BW'(IN_WIDTH - 1);

    state_e            state_q;
    logic              mode_q;
    logic              busy_q;
    logic              done_q;
    logic              preclk_q, preclk_d;
    logic [8*SIZE-1:0] hold_q, hold_d;
    logic              hold_vld_q, hold_vld_d;
    logic              shift_vld_q, shift_vld_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]     acc_cnt_q, acc_cnt_d;
    logic [CW-1:0]     emit_cnt_q, emit_cnt_d;

    logic              fire;
    logic              word_end;
    logic              shift_free;
    logic              load_hold;
    logic              load_bypass;
    logic              shift_load;
    logic              clr;
    logic              last_out;
    logic [8*SIZE-1:0] load_data;
    logic [LANES-1:0]  lane_msb;

    assign vec_ready   = busy_q && !hold_vld_q && (acc_cnt_q < CNT_SIZE);
    assign fire        = vec_valid && vec_ready;
    assign word_end    = shift_vld_q && (bit_cnt_q == BIT_LAST);
    assign shift_free  = !shift_vld_q || word_end;
    assign load_hold   = shift_free && hold_vld_q;
    // With nothing queued, a fresh vector skips the hold register so streaming resumes next cycle.
    assign load_bypass = shift_free && !hold_vld_q && fire;
    assign shift_load  = load_hold || load_bypass;
    assign load_data   = hold_vld_q ? hold_q : vec_data;
    assign clr         = (state_q == ST_IDLE) && start;
    assign last_out    = (emit_cnt_q == CNT_SIZE) && !shift_vld_q
                         && ((mode_q == MODE_ACT) || preclk_q);

    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        if (load_hold) begin
            hold_vld_d = 1'b0;
        end
        if (fire && !load_bypass) begin
            hold_d     = vec_data;
            hold_vld_d = 1'b1;
        end

        shift_vld_d = shift_vld_q;
        if (shift_load) begin
            shift_vld_d = 1'b1;
        end else if (word_end) begin
            shift_vld_d = 1'b0;
        end

        bit_cnt_d = bit_cnt_q;
        if (word_end) begin
            bit_cnt_d = '0;
        end else if (shift_vld_q) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
        end

        acc_cnt_d  = clr ? '0 : acc_cnt_q + CW'(fire);
        emit_cnt_d = clr ? '0 : emit_cnt_q + CW'(word_end);
        preclk_d   = word_end && (mode_q == MODE_WEIGHT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= '0;
            hold_vld_q  <= 1'b0;
            shift_vld_q <= 1'b0;
            bit_cnt_q   <= '0;
            acc_cnt_q   <= '0;
            emit_cnt_q  <= '0;
            preclk_q    <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            shift_vld_q <= shift_vld_d;
            bit_cnt_q   <= bit_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
            emit_cnt_q  <= emit_cnt_d;
            preclk_q    <= preclk_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_WEIGHT;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        mode_q  <= mode;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (last_out) begin
                        state_q <= ST_FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_FIN:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Lane j owns bytes RPL*j .. RPL*j+RPL-1; the highest byte sits at the MSB and goes out first.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        sa_lane_shifter #(
            .RPL(RPL)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .load_i (shift_load),
            .shift_i(shift_vld_q),
            .data_i (load_data[8*RPL*j +: 8*RPL]),
            .msb_o  (lane_msb[j])
        );
    end

    assign data_in   = lane_msb & {LANES{shift_vld_q}};
    assign en_in     = {LANES{shift_vld_q}};
    assign bit_valid = shift_vld_q;
    assign preclk    = preclk_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sa_bitserial_feeder.sv
// Directed bench for sa_bitserial_feeder: reset, weight preload, activation
// streaming, underflow, backpressure and reset-abort scenarios.
module tb_sa_bitserial_feeder;

    localparam int SIZE     = 16;
    localparam int IN_WIDTH = 16;
    localparam int RPL      = IN_WIDTH / 8;
    localparam int LANES    = SIZE * 8 / IN_WIDTH;
    localparam int NBITS    = SIZE * IN_WIDTH;
    localparam int CAPN     = NBITS + 64;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              mode;
    logic [8*SIZE-1:0] vec_data;
    logic              vec_valid;
    logic              vec_ready;
    logic [LANES-1:0]  data_in;
    logic [LANES-1:0]  en_in;
    logic              bit_valid;
    logic              preclk;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_fails  = 0;

    logic [8*SIZE-1:0] vecs [SIZE];
    logic [LANES-1:0]  cap_bits [CAPN];
    int nbits, first_bv, last_bv, done_cyc, done_cnt, hs_cnt, bad_idle, bad_en, busy_at_done;
    int pre_q[$];

    sa_bitserial_feeder #(
        .SIZE    (SIZE),
        .IN_WIDTH(IN_WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .vec_data (vec_data),
        .vec_valid(vec_valid),
        .vec_ready(vec_ready),
        .data_in  (data_in),
        .en_in    (en_in),
        .bit_valid(bit_valid),
        .preclk   (preclk),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected per-lane words: k-th emitted bit of lane j is bit 7-k%8 of byte RPL*j+RPL-1-k/8.
    function automatic logic [LANES*IN_WIDTH-1:0] exp_vec(input int v);
        logic [LANES*IN_WIDTH-1:0] w;
        w = '0;
        for (int j = 0; j < LANES; j++) begin
            for (int k = 0; k < IN_WIDTH; k++) begin
                int byte_i;
                int bit_i;
                byte_i = RPL * j + RPL - 1 - k / 8;
                bit_i  = 7 - k % 8;
                w[j*IN_WIDTH + IN_WIDTH - 1 - k] = vecs[v][8*byte_i + bit_i];
            end
        end
        return w;
    endfunction

    function automatic logic [LANES*IN_WIDTH-1:0] got_vec(input int v);
        logic [LANES*IN_WIDTH-1:0] w;
        w = '0;
        for (int j = 0; j < LANES; j++) begin
            for (int k = 0; k < IN_WIDTH; k++) begin
                w[j*IN_WIDTH + IN_WIDTH - 1 - k] = cap_bits[v*IN_WIDTH + k][j];
            end
        end
        return w;
    endfunction

    function automatic logic [8*SIZE-1:0] junk_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Runs one transfer and records what the DUT emitted; cycle 0 is the first cycle after start is sampled.
    task automatic drive_transfer(input logic md, input int gap_at, input int gap_len,
                                  input bit junk, input int abort_cyc, input int restart_cyc);
        int vi;
        int gap_left;
        nbits = 0; first_bv = -1; last_bv = -1; done_cyc = -1; done_cnt = 0;
        hs_cnt = 0; bad_idle = 0; bad_en = 0; busy_at_done = -1;
        pre_q.delete();
        for (int i = 0; i < CAPN; i++) cap_bits[i] = '0;
        @(posedge clk); #1;
        start = 1'b1;
        mode  = md;
        @(posedge clk); #1;
        start    = 1'b0;
        vi       = 0;
        gap_left = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == abort_cyc) begin
                vec_valid = 1'b0;
                start     = 1'b0;
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                return;
            end
            if (bit_valid) begin
                if (nbits < CAPN) cap_bits[nbits] = data_in;
                nbits++;
                if (first_bv < 0) first_bv = cyc;
                last_bv = cyc;
                if (en_in !== {LANES{1'b1}}) bad_en++;
            end else begin
                if (en_in !== '0 || data_in !== '0) bad_idle++;
            end
            if (preclk) pre_q.push_back(cyc);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc     = cyc;
                    busy_at_done = int'(busy);
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;

            start = (cyc == restart_cyc);
            mode  = (cyc == restart_cyc) ? ~md : md;
            if (gap_left > 0) begin
                gap_left--;
                vec_valid = 1'b0;
                vec_data  = junk_data();
            end else if (vi < SIZE) begin
                vec_valid = 1'b1;
                vec_data  = (junk && !vec_ready) ? junk_data() : vecs[vi];
            end else begin
                vec_valid = junk;
                vec_data  = junk_data();
            end
            if (vec_valid && vec_ready) begin
                hs_cnt++;
                vi++;
                if (vi == gap_at) gap_left = gap_len;
            end
            @(posedge clk); #1;
        end
        vec_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic test_reset();
        int bv_seen;
        int rdy_seen;
        int busy_seen;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({data_in, en_in, bit_valid, preclk, busy, done, vec_ready} !== '0) begin
            n_fails++;
            $display("FAIL reset_outputs: got %h, want 0",
                     {data_in, en_in, bit_valid, preclk, busy, done, vec_ready});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        vec_valid = 1'b1;
        vec_data  = {4{32'hA5A5_5A5A}};
        bv_seen = 0; rdy_seen = 0; busy_seen = 0;
        repeat (10) begin
            if (bit_valid) bv_seen++;
            if (vec_ready) rdy_seen++;
            if (busy) busy_seen++;
            @(posedge clk); #1;
        end
        vec_valid = 1'b0;
        n_checks++;
        if (rdy_seen !== 0) begin
            n_fails++;
            $display("FAIL idle_vec_ready: got %0d ready cycles, want 0", rdy_seen);
        end
        n_checks++;
        if (bv_seen !== 0) begin
            n_fails++;
            $display("FAIL idle_bit_valid: got %0d valid cycles, want 0", bv_seen);
        end
        n_checks++;
        if (busy_seen !== 0) begin
            n_fails++;
            $display("FAIL idle_busy: got %0d busy cycles, want 0", busy_seen);
        end
    endtask

    task automatic test_weight_preload();
        logic [LANES*IN_WIDTH-1:0] e, g;
        int spacing_bad;
        int p0;
        int plast;
        for (int v = 0; v < SIZE; v++)
            for (int b = 0; b < SIZE; b++)
                vecs[v][8*b +: 8] = 8'(16 * v + b + 1);
        // A second start (with the other mode) mid-transfer must be ignored.
        drive_transfer(1'b0, -1, 0, 1'b0, -1, 50);
        g = got_vec(0);
        n_checks++;
        if (g[IN_WIDTH-1:0] !== 16'h0201) begin
            n_fails++;
            $display("FAIL weight_lane0_first: got %h, want 0201", g[IN_WIDTH-1:0]);
        end
        n_checks++;
        if (pre_q.size() !== SIZE) begin
            n_fails++;
            $display("FAIL weight_preclk_count: got %0d, want %0d", pre_q.size(), SIZE);
        end
        p0    = (pre_q.size() > 0) ? pre_q[0] : -1;
        plast = (pre_q.size() > 0) ? pre_q[pre_q.size()-1] : -1;
        n_checks++;
        if (p0 !== 17) begin
            n_fails++;
            $display("FAIL weight_first_preclk: got cycle %0d, want 17", p0);
        end
        spacing_bad = 0;
        for (int i = 1; i < pre_q.size(); i++)
            if (pre_q[i] - pre_q[i-1] != IN_WIDTH) spacing_bad++;
        n_checks++;
        if (spacing_bad !== 0) begin
            n_fails++;
            $display("FAIL weight_preclk_spacing: got %0d bad gaps, want 0", spacing_bad);
        end
        n_checks++;
        if (done_cyc !== 258 || done_cyc !== plast + 1) begin
            n_fails++;
            $display("FAIL weight_done_cycle: got %0d (last preclk %0d), want 258", done_cyc, plast);
        end
        n_checks++;
        if (done_cnt !== 1 || busy_at_done !== 0) begin
            n_fails++;
            $display("FAIL weight_done_pulse: got %0d pulses busy=%0d, want 1 pulse busy=0",
                     done_cnt, busy_at_done);
        end
        n_checks++;
        if (bad_en !== 0 || bad_idle !== 0 || nbits !== NBITS) begin
            n_fails++;
            $display("FAIL weight_enables: got bad_en=%0d bad_idle=%0d bits=%0d, want 0 0 %0d",
                     bad_en, bad_idle, nbits, NBITS);
        end
        for (int v = 0; v < SIZE; v++) begin
            e = exp_vec(v);
            g = got_vec(v);
            n_checks++;
            if (g !== e) begin
                n_fails++;
                $display("FAIL weight_stream v%0d: got %h, want %h", v, g, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [LANES*IN_WIDTH-1:0] e, g;
        for (int v = 0; v < SIZE; v++)
            for (int b = 0; b < SIZE; b++)
                vecs[v][8*b +: 8] = 8'((8'hFF - b) ^ (v << 4));
        drive_transfer(1'b1, -1, 0, 1'b0, -1, -1);
        n_checks++;
        if (nbits !== NBITS || first_bv !== 1 || last_bv !== NBITS) begin
            n_fails++;
            $display("FAIL act_gapless: got bits=%0d first=%0d last=%0d, want %0d 1 %0d",
                     nbits, first_bv, last_bv, NBITS, NBITS);
        end
        n_checks++;
        if (pre_q.size() !== 0) begin
            n_fails++;
            $display("FAIL act_no_preclk: got %0d strobes, want 0", pre_q.size());
        end
        g = got_vec(0);
        n_checks++;
        if (g[7*IN_WIDTH +: IN_WIDTH] !== 16'hF0F1) begin
            n_fails++;
            $display("FAIL act_lane7_first: got %h, want f0f1", g[7*IN_WIDTH +: IN_WIDTH]);
        end
        n_checks++;
        if (done_cyc !== 258 || done_cnt !== 1) begin
            n_fails++;
            $display("FAIL act_done: got cycle %0d count %0d, want 258 1", done_cyc, done_cnt);
        end
        for (int v = 0; v < SIZE; v++) begin
            e = exp_vec(v);
            g = got_vec(v);
            n_checks++;
            if (g !== e) begin
                n_fails++;
                $display("FAIL act_stream v%0d: got %h, want %h", v, g, e);
            end
        end
    endtask

    task automatic test_underflow();
        logic [LANES*IN_WIDTH-1:0] e, g;
        int idle_mid;
        for (int v = 0; v < SIZE; v++)
            for (int b = 0; b < SIZE; b++)
                vecs[v][8*b +: 8] = 8'(8'h3C ^ (7 * v + b));
        // Hold off long enough after vector 3 that both buffers drain: 10 idle cycles.
        drive_transfer(1'b0, 4, 40, 1'b0, -1, -1);
        idle_mid = last_bv - first_bv + 1 - nbits;
        n_checks++;
        if (nbits !== NBITS || idle_mid !== 10) begin
            n_fails++;
            $display("FAIL underflow_gap: got bits=%0d idle=%0d, want %0d 10", nbits, idle_mid, NBITS);
        end
        n_checks++;
        if (bad_idle !== 0 || bad_en !== 0) begin
            n_fails++;
            $display("FAIL underflow_gating: got bad_idle=%0d bad_en=%0d, want 0 0", bad_idle, bad_en);
        end
        n_checks++;
        if (pre_q.size() !== SIZE) begin
            n_fails++;
            $display("FAIL underflow_preclk: got %0d, want %0d", pre_q.size(), SIZE);
        end
        n_checks++;
        if (done_cyc !== 268) begin
            n_fails++;
            $display("FAIL underflow_done: got cycle %0d, want 268", done_cyc);
        end
        for (int v = 0; v < SIZE; v++) begin
            e = exp_vec(v);
            g = got_vec(v);
            n_checks++;
            if (g !== e) begin
                n_fails++;
                $display("FAIL underflow_stream v%0d: got %h, want %h", v, g, e);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [LANES*IN_WIDTH-1:0] e, g;
        for (int v = 0; v < SIZE; v++)
            for (int b = 0; b < SIZE; b++)
                vecs[v][8*b +: 8] = 8'(8'hC5 + 11 * v + 3 * b);
        drive_transfer(1'b1, -1, 0, 1'b1, -1, -1);
        n_checks++;
        if (hs_cnt !== SIZE) begin
            n_fails++;
            $display("FAIL bp_handshakes: got %0d, want %0d", hs_cnt, SIZE);
        end
        n_checks++;
        if (nbits !== NBITS || done_cyc !== 258) begin
            n_fails++;
            $display("FAIL bp_length: got bits=%0d done=%0d, want %0d 258", nbits, done_cyc, NBITS);
        end
        for (int v = 0; v < SIZE; v++) begin
            e = exp_vec(v);
            g = got_vec(v);
            n_checks++;
            if (g !== e) begin
                n_fails++;
                $display("FAIL bp_stream v%0d: got %h, want %h", v, g, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [LANES*IN_WIDTH-1:0] e, g;
        for (int v = 0; v < SIZE; v++)
            for (int b = 0; b < SIZE; b++)
                vecs[v][8*b +: 8] = 8'(8'hE1 ^ (5 * v + 9 * b));
        // Cycle 117 is mid-way through vector 7 (bits 113..128).
        drive_transfer(1'b0, -1, 0, 1'b0, 117, -1);
        n_checks++;
        if ({data_in, en_in, bit_valid, preclk, busy, done, vec_ready} !== '0) begin
            n_fails++;
            $display("FAIL abort_outputs: got %h, want 0",
                     {data_in, en_in, bit_valid, preclk, busy, done, vec_ready});
        end
        n_checks++;
        if (pre_q.size() !== 7) begin
            n_fails++;
            $display("FAIL abort_preclk_before: got %0d, want 7", pre_q.size());
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int v = 0; v < SIZE; v++)
            for (int b = 0; b < SIZE; b++)
                vecs[v][8*b +: 8] = 8'(8'h17 + 13 * v + 29 * b);
        drive_transfer(1'b0, -1, 0, 1'b0, -1, -1);
        n_checks++;
        if (pre_q.size() !== SIZE || nbits !== NBITS) begin
            n_fails++;
            $display("FAIL restart_counts: got preclk=%0d bits=%0d, want %0d %0d",
                     pre_q.size(), nbits, SIZE, NBITS);
        end
        n_checks++;
        if (done_cyc !== 258) begin
            n_fails++;
            $display("FAIL restart_done: got cycle %0d, want 258", done_cyc);
        end
        for (int v = 0; v < SIZE; v++) begin
            e = exp_vec(v);
            g = got_vec(v);
            n_checks++;
            if (g !== e) begin
                n_fails++;
                $display("FAIL restart_stream v%0d: got %h, want %h", v, g, e);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        start     = 1'b0;
        mode      = 1'b0;
        vec_valid = 1'b0;
        vec_data  = '0;
        test_reset();
        test_weight_preload();
        test_back_to_back();
        test_underflow();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
